// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//   Operand forwarding selects and load-use / memory-wait stall control for a
//   five-stage pipeline. Forwarding priority is EX/MEM, then MEM/WB, then a
//   one-entry write-back history that remembers the instruction that retired
//   on the previous clock.
//
//   Optional feature macro: FWD_STALL_CNT_EN
//     When defined, adds output stall_cnt, a saturating count of clocks with
//     pc_write low. When undefined, the port and the counter are absent.
//
// Parameters
//   REG_AW    register-address width
//   LOAD_LAT  load-use stall cycles per hazard (1..4)
//   CNT_W     stall-counter width
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   ex_mem_rd/rw, mem_wb_rd/rw     destination fields and write enables
//   id_ex_rs/rt/rd, id_ex_memread  EX-stage operands, destination, load flag
//   if_id_rs/rt                    ID-stage source operands
//   mem_busy                       data memory not ready
//   fa, fb                         operand mux selects (0 rf,1 MEM/WB,2 EX/MEM,3 hist)
//   pc_write, if_id_write          PC and IF/ID load enables
//   id_ex_flush, freeze            bubble insert, whole-pipe hold
//   stall_cnt                      stall clock count (FWD_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic [REG_AW-1:0] id_ex_rs,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              ex_mem_rw,
  input  logic              mem_wb_rw,
  input  logic              id_ex_memread,
  input  logic              mem_busy,
  output logic [1:0]        fa,
  output logic [1:0]        fb,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_flush,
  output logic              freeze
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] CNT_INIT   = 2'(LOAD_LAT - 1);
  localparam bit         MULTI_STALL = (LOAD_LAT > 1);

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  state_e            eff_state;
  logic [1:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] hist_rd_q;
  logic              hist_rw_q;
  logic              hz;

  // Forwarding source select for one operand, highest priority first.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] em_rd,
    input logic              em_rw,
    input logic [REG_AW-1:0] mw_rd,
    input logic              mw_rw,
    input logic [REG_AW-1:0] h_rd,
    input logic              h_rw
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (em_rw && (em_rd != '0) && (em_rd == src))      sel = 2'd2;
    else if (mw_rw && (mw_rd != '0) && (mw_rd == src)) sel = 2'd1;
    else if (h_rw && (h_rd != '0) && (h_rd == src))    sel = 2'd3;
    return sel;
  endfunction

  assign fa = fwd_sel(id_ex_rs, ex_mem_rd, ex_mem_rw, mem_wb_rd, mem_wb_rw,
                      hist_rd_q, hist_rw_q);
  assign fb = fwd_sel(id_ex_rt, ex_mem_rd, ex_mem_rw, mem_wb_rd, mem_wb_rw,
                      hist_rd_q, hist_rw_q);

  assign hz = id_ex_memread && (id_ex_rd != '0) &&
              ((id_ex_rd == if_id_rs) || (id_ex_rd == if_id_rt));

  // State, stall-progress and return registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write-back history; held while the pipe is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_rd_q <= '0;
      hist_rw_q <= 1'b0;
    end else if (!freeze) begin
      hist_rd_q <= mem_wb_rd;
      hist_rw_q <= mem_wb_rw;
    end
  end

  // Next-state and control outputs. MEM_WAIT resumes by behaving exactly as
  // the saved state would, so a released wait costs no extra cycle.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_flush = 1'b0;
    freeze      = 1'b0;
    eff_state   = (state_q == MEM_WAIT) ? ret_q : state_q;

    if (!rst_n) begin
      // Reset forces free-running control regardless of inputs.
    end else if (mem_busy) begin
      freeze      = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      state_d     = MEM_WAIT;
      if (state_q != MEM_WAIT) ret_d = state_q;
    end else begin
      case (eff_state)
        LU_STALL: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          cnt_d       = cnt_q - 2'd1;
          state_d     = (cnt_q == 2'd1) ? IDLE : LU_STALL;
        end
        default: begin
          state_d = IDLE;
          if (hz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            if (MULTI_STALL) begin
              state_d = LU_STALL;
              cnt_d   = CNT_INIT;
            end
          end
        end
      endcase
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of clocks with the PC held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
//   Table of forwarding vectors applied under reset, hand-written stall and
//   reset sequences, then randomized traffic against a behavioural model that
//   tracks "remaining stall cycles" and the write-back history directly.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned LOAD_LAT = 3;
  localparam int unsigned CNT_W    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [REG_AW-1:0] ex_mem_rd, mem_wb_rd, id_ex_rs, id_ex_rt, id_ex_rd;
  logic [REG_AW-1:0] if_id_rs, if_id_rt;
  logic              ex_mem_rw, mem_wb_rw, id_ex_memread, mem_busy;
  logic [1:0]        fa, fb;
  logic              pc_write, if_id_write, id_ex_flush, freeze;
`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .REG_AW  (REG_AW),
    .LOAD_LAT(LOAD_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_mem_rd    (ex_mem_rd),
    .mem_wb_rd    (mem_wb_rd),
    .id_ex_rs     (id_ex_rs),
    .id_ex_rt     (id_ex_rt),
    .id_ex_rd     (id_ex_rd),
    .if_id_rs     (if_id_rs),
    .if_id_rt     (if_id_rt),
    .ex_mem_rw    (ex_mem_rw),
    .mem_wb_rw    (mem_wb_rw),
    .id_ex_memread(id_ex_memread),
    .mem_busy     (mem_busy),
    .fa           (fa),
    .fb           (fb),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .id_ex_flush  (id_ex_flush),
    .freeze       (freeze)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  typedef struct {
    logic [4:0] em_rd;
    logic       em_rw;
    logic [4:0] mw_rd;
    logic       mw_rw;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mr;
    logic [4:0] xrd;
    logic [4:0] frs;
    logic [4:0] frt;
    logic       busy;
    logic [1:0] efa;
    logic [1:0] efb;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_inputs();
    ex_mem_rd = '0; mem_wb_rd = '0; id_ex_rs = '0; id_ex_rt = '0;
    id_ex_rd = '0; if_id_rs = '0; if_id_rt = '0;
    ex_mem_rw = 1'b0; mem_wb_rw = 1'b0; id_ex_memread = 1'b0; mem_busy = 1'b0;
  endtask

  // Leaves the bench just after a rising edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Check control outputs mid-cycle, then move to just after the next edge.
  task automatic expect_ctl(input string tag, input logic pc, input logic ifid,
                            input logic fl, input logic fr);
    @(negedge clk);
    chk({tag, ".pc_write"},    32'(pc_write),    32'(pc));
    chk({tag, ".if_id_write"}, 32'(if_id_write), 32'(ifid));
    chk({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(fl));
    chk({tag, ".freeze"},      32'(freeze),      32'(fr));
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference ----------------
  int         m_rem;
  logic [4:0] m_hrd;
  logic       m_hrw;
  int         m_sc;

  function automatic int ref_sel(input int src, input int em_rd, input int em_rw,
                                 input int mw_rd, input int mw_rw,
                                 input int h_rd, input int h_rw);
    if (em_rw == 1 && em_rd != 0 && em_rd == src) return 2;
    if (mw_rw == 1 && mw_rd != 0 && mw_rd == src) return 1;
    if (h_rw == 1 && h_rd != 0 && h_rd == src)    return 3;
    return 0;
  endfunction

  task automatic rand_cycle(input int idx);
    int  hrd, hrw, efa, efb, nrem, esc;
    bit  hz, epc, eifid, efl, efr;
    @(posedge clk);
    #1;
    rst_n         = (idx == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
    ex_mem_rd     = 5'($urandom_range(0, 3));
    mem_wb_rd     = 5'($urandom_range(0, 3));
    id_ex_rs      = 5'($urandom_range(0, 3));
    id_ex_rt      = 5'($urandom_range(0, 3));
    id_ex_rd      = 5'($urandom_range(0, 3));
    if_id_rs      = 5'($urandom_range(0, 3));
    if_id_rt      = 5'($urandom_range(0, 3));
    ex_mem_rw     = 1'($urandom_range(0, 1));
    mem_wb_rw     = 1'($urandom_range(0, 1));
    id_ex_memread = ($urandom_range(0, 2) == 0);
    mem_busy      = ($urandom_range(0, 6) == 0);
    @(negedge clk);

    hrd = rst_n ? int'(m_hrd) : 0;
    hrw = rst_n ? int'(m_hrw) : 0;
    efa = ref_sel(int'(id_ex_rs), int'(ex_mem_rd), int'(ex_mem_rw),
                  int'(mem_wb_rd), int'(mem_wb_rw), hrd, hrw);
    efb = ref_sel(int'(id_ex_rt), int'(ex_mem_rd), int'(ex_mem_rw),
                  int'(mem_wb_rd), int'(mem_wb_rw), hrd, hrw);
    hz  = id_ex_memread && (id_ex_rd != 0) &&
          ((id_ex_rd == if_id_rs) || (id_ex_rd == if_id_rt));
    nrem = m_rem;
    {epc, eifid, efl, efr} = 4'b1100;
    if (!rst_n) begin
      nrem = 0;
    end else if (mem_busy) begin
      {epc, eifid, efl, efr} = 4'b0001;
    end else if (m_rem > 0) begin
      {epc, eifid, efl, efr} = 4'b0010;
      nrem = m_rem - 1;
    end else if (hz) begin
      {epc, eifid, efl, efr} = 4'b0010;
      nrem = LOAD_LAT - 1;
    end
    esc = rst_n ? m_sc : 0;

    chk("rnd.fa",          32'(fa),          32'(efa));
    chk("rnd.fb",          32'(fb),          32'(efb));
    chk("rnd.pc_write",    32'(pc_write),    32'(epc));
    chk("rnd.if_id_write", 32'(if_id_write), 32'(eifid));
    chk("rnd.id_ex_flush", 32'(id_ex_flush), 32'(efl));
    chk("rnd.freeze",      32'(freeze),      32'(efr));
`ifdef FWD_STALL_CNT_EN
    chk("rnd.stall_cnt",   32'(stall_cnt),   32'(esc));
`else
    if (esc < 0) $display("unexpected negative model count");
`endif

    // Model state as of the coming rising edge.
    if (!rst_n) begin
      m_rem = 0; m_hrd = '0; m_hrw = 1'b0; m_sc = 0;
    end else begin
      m_rem = nrem;
      if (!mem_busy) begin
        m_hrd = mem_wb_rd;
        m_hrw = mem_wb_rw;
      end
      if (!epc && m_sc < (2 ** CNT_W) - 1) m_sc++;
    end
  endtask

  initial begin
    //            em_rd em_rw mw_rd mw_rw rs  rt  mr  xrd frs frt busy efa efb
    tbl[0] = '{5'd8,  1'b1, 5'd8,  1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd2, 2'd0};
    tbl[1] = '{5'd0,  1'b1, 5'd8,  1'b1, 5'd8, 5'd8, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd1, 2'd1};
    tbl[2] = '{5'd3,  1'b0, 5'd3,  1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 2'd1, 2'd1};
    tbl[3] = '{5'd3,  1'b1, 5'd4,  1'b1, 5'd4, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 2'd1, 2'd2};
    tbl[4] = '{5'd5,  1'b0, 5'd5,  1'b0, 5'd5, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0};
    tbl[5] = '{5'd0,  1'b1, 5'd0,  1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0};
    tbl[6] = '{5'd31, 1'b1, 5'd31, 1'b1, 5'd31, 5'd30, 1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 2'd2, 2'd0};
    tbl[7] = '{5'd2,  1'b1, 5'd6,  1'b1, 5'd6, 5'd2, 1'b1, 5'd6, 5'd0, 5'd6, 1'b0, 2'd1, 2'd2};

    // Forwarding vectors under reset: history is zero, control is forced free.
    rst_n = 1'b0;
    clr_inputs();
    #12;
    for (int i = 0; i < 8; i++) begin
      ex_mem_rd = tbl[i].em_rd; ex_mem_rw = tbl[i].em_rw;
      mem_wb_rd = tbl[i].mw_rd; mem_wb_rw = tbl[i].mw_rw;
      id_ex_rs  = tbl[i].rs;    id_ex_rt  = tbl[i].rt;
      id_ex_memread = tbl[i].mr; id_ex_rd = tbl[i].xrd;
      if_id_rs  = tbl[i].frs;   if_id_rt  = tbl[i].frt;
      mem_busy  = tbl[i].busy;
      #3;
      chk($sformatf("tbl%0d.fa", i), 32'(fa), 32'(tbl[i].efa));
      chk($sformatf("tbl%0d.fb", i), 32'(fb), 32'(tbl[i].efb));
      chk($sformatf("tbl%0d.pc_write", i),    32'(pc_write),    32'd1);
      chk($sformatf("tbl%0d.if_id_write", i), 32'(if_id_write), 32'd1);
      chk($sformatf("tbl%0d.id_ex_flush", i), 32'(id_ex_flush), 32'd0);
      chk($sformatf("tbl%0d.freeze", i),      32'(freeze),      32'd0);
`ifdef FWD_STALL_CNT_EN
      chk($sformatf("tbl%0d.stall_cnt", i),   32'(stall_cnt),   32'd0);
`endif
      #4;
    end

    // Write-back history forwarding and hold under freeze.
    do_reset();
    mem_wb_rw = 1'b1; mem_wb_rd = 5'd9;
    @(posedge clk); #1;
    mem_wb_rw = 1'b0; id_ex_rt = 5'd9;
    #1 chk("hist.fb_hit", 32'(fb), 32'd3);
    @(posedge clk); #1;
    #1 chk("hist.fb_retired", 32'(fb), 32'd0);
    mem_wb_rw = 1'b1; mem_wb_rd = 5'd0;
    @(posedge clk); #1;
    mem_wb_rw = 1'b0; id_ex_rt = 5'd0;
    #1 chk("hist.fb_r0", 32'(fb), 32'd0);
    mem_wb_rw = 1'b1; mem_wb_rd = 5'd7; mem_busy = 1'b1;
    @(posedge clk); #1;
    mem_wb_rw = 1'b0; mem_busy = 1'b0; id_ex_rt = 5'd7;
    #1 chk("hist.fb_frozen", 32'(fb), 32'd0);
    @(posedge clk); #1;
    #1 chk("hist.fb_after_freeze", 32'(fb), 32'd0);

    // Load-use hazard: exactly LOAD_LAT stall cycles.
    do_reset();
    id_ex_memread = 1'b1; id_ex_rd = 5'd5; if_id_rt = 5'd5;
    expect_ctl("lu.c0", 1'b0, 1'b0, 1'b1, 1'b0);
    clr_inputs();
    expect_ctl("lu.c1", 1'b0, 1'b0, 1'b1, 1'b0);
    expect_ctl("lu.c2", 1'b0, 1'b0, 1'b1, 1'b0);
    expect_ctl("lu.c3", 1'b1, 1'b1, 1'b0, 1'b0);

    // Memory wait in the middle of a load-use stall.
    do_reset();
    id_ex_memread = 1'b1; id_ex_rd = 5'd5; if_id_rt = 5'd5;
    expect_ctl("mw.c0", 1'b0, 1'b0, 1'b1, 1'b0);
    clr_inputs();
    mem_busy = 1'b1;
    expect_ctl("mw.c1", 1'b0, 1'b0, 1'b0, 1'b1);
    expect_ctl("mw.c2", 1'b0, 1'b0, 1'b0, 1'b1);
    mem_busy = 1'b0;
    expect_ctl("mw.c3", 1'b0, 1'b0, 1'b1, 1'b0);
    expect_ctl("mw.c4", 1'b0, 1'b0, 1'b1, 1'b0);
    expect_ctl("mw.c5", 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef FWD_STALL_CNT_EN
    chk("mw.stall_cnt_sat", 32'(stall_cnt), 32'd3);
    expect_ctl("mw.c6", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mw.stall_cnt_held", 32'(stall_cnt), 32'd3);
`endif

    // Reset asserted in the second LU_STALL cycle.
    do_reset();
    id_ex_memread = 1'b1; id_ex_rd = 5'd5; if_id_rs = 5'd5;
    expect_ctl("rs.c0", 1'b0, 1'b0, 1'b1, 1'b0);
    clr_inputs();
    expect_ctl("rs.c1", 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("rs.c2_stalled", 32'(pc_write), 32'd0);
    rst_n = 1'b0;
    #1 chk("rs.c2_pc_write", 32'(pc_write), 32'd1);
    chk("rs.c2_flush", 32'(id_ex_flush), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_ctl("rs.r0", 1'b1, 1'b1, 1'b0, 1'b0);
    expect_ctl("rs.r1", 1'b1, 1'b1, 1'b0, 1'b0);
    expect_ctl("rs.r2", 1'b1, 1'b1, 1'b0, 1'b0);

    // Randomized traffic against the reference.
    m_rem = 0; m_hrd = '0; m_hrw = 1'b0; m_sc = 0;
    for (int n = 0; n < 800; n++) rand_cycle(n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter LOAD_LAT, default 1, legal range 1..4, meaning load-use stall cycles per hazard.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports ex_mem_rd, mem_wb_rd, id_ex_rs, id_ex_rt, id_ex_rd, if_id_rs, if_id_rt, input, REG_AW, pipeline-register register fields.
REQ-007 The block SHALL have ports ex_mem_rw, mem_wb_rw, input, 1, register-write enables.
REQ-008 The block SHALL have port id_ex_memread, input, 1, meaning the EX-stage instruction is a load.
REQ-009 The block SHALL have port mem_busy, input, 1, meaning data memory is not ready.
REQ-010 The block SHALL have ports fa, fb, output, 2, operand-A/B mux selects: 0 regfile, 1 MEM/WB, 2 EX/MEM, 3 WB history.
REQ-011 The block SHALL have ports pc_write, if_id_write, output, 1, PC and IF/ID load enables.
REQ-012 The block SHALL have ports id_ex_flush, freeze, output, 1, bubble insertion and whole-pipe hold.
REQ-013 The block SHALL have port stall_cnt, output, CNT_W, present only with FWD_STALL_CNT_EN.

Function
REQ-014 fa SHALL be combinational with priority: 2 if ex_mem_rw, ex_mem_rd!=0, ex_mem_rd==id_ex_rs; else 1 on the same test with mem_wb_*; else 3 on the same test with hist_rd/hist_rw; else 0.
REQ-015 fb SHALL use the REQ-014 rule with id_ex_rt.
REQ-016 hist_rd/hist_rw SHALL register mem_wb_rd/mem_wb_rw every clock when freeze==0 and hold when freeze==1.
REQ-017 Hazard hz SHALL be id_ex_memread && id_ex_rd!=0 && (id_ex_rd==if_id_rs || id_ex_rd==if_id_rt).
REQ-018 FSM states SHALL be IDLE, LU_STALL, MEM_WAIT; a down-counter cnt of width 2 and a return register ret hold stall progress.
REQ-019 In any state, mem_busy==1 SHALL drive freeze=1, pc_write=0, if_id_write=0, id_ex_flush=0 combinationally, enter MEM_WAIT, save the pre-wait state in ret (not overwritten while in MEM_WAIT), and hold cnt.
REQ-020 MEM_WAIT with mem_busy==0 SHALL output as ret's state would and transition as ret's state would this cycle.
REQ-021 IDLE with hz and mem_busy==0 SHALL drive pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; if LOAD_LAT>1 go to LU_STALL with cnt=LOAD_LAT-1, else stay IDLE.
REQ-022 LU_STALL SHALL drive pc_write=0, if_id_write=0, id_ex_flush=1, decrement cnt, and return to IDLE when cnt==1, giving exactly LOAD_LAT stall cycles per hazard.
REQ-023 IDLE without hz or mem_busy SHALL drive pc_write=1, if_id_write=1, id_ex_flush=0, freeze=0.
REQ-024 hz SHALL be ignored in LU_STALL and MEM_WAIT.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, cnt=0, ret=IDLE, hist_rd=0, hist_rw=0, stall_cnt=0, including mid-stall or mid-wait.
REQ-026 During reset, outputs SHALL be pc_write=1, if_id_write=1, id_ex_flush=0, freeze=0, with fa/fb following REQ-014/015 on zeroed history.

Configuration
REQ-027 With FWD_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 each clock with pc_write==0 and saturate at all-ones.
REQ-028 Without FWD_STALL_CNT_EN, the stall_cnt port and counter SHALL be absent; all other behaviour is unchanged.

Verification
REQ-029 ex_mem_rw=1, ex_mem_rd=8, mem_wb_rw=1, mem_wb_rd=8, id_ex_rs=8 -> fa=2; ex_mem_rd=0 -> fa=1.
REQ-030 mem_wb_rw=1, mem_wb_rd=9 for one clock, then mem_wb_rw=0, id_ex_rt=9 -> fb=3 the next cycle; with mem_wb_rd=0 -> fb=0.
REQ-031 LOAD_LAT=3, id_ex_memread=1, id_ex_rd=5, if_id_rt=5 -> pc_write=0, id_ex_flush=1 for exactly 3 cycles, then pc_write=1.
REQ-032 LOAD_LAT=3, mem_busy=1 for 2 cycles entered after the first stall cycle -> freeze=1 for 2 cycles, then the 2 remaining stall cycles.
REQ-033 rst_n low in the second cycle of LU_STALL -> pc_write=1 immediately; no further stall after release with hz=0.
REQ-034 FWD_STALL_CNT_EN, CNT_W=2, 5 stall cycles -> stall_cnt=3, held.
